// File: rtl/dff_mon_pkg.sv
// Shared types and constants for the DFF response monitor.
package dff_mon_pkg;

  // Run-control states of the monitor.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } mon_state_e;

  // Default width of every counter and index output.
  localparam int DEF_CNT_W = 16;

  // Width of the settle-delay counter (holds SETTLE_CYC, 1..255).
  localparam int SETTLE_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Synchronous reset/clear, then increment unless already saturated.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dff_response_monitor.sv
// Response-side checker for an enabled D flip-flop: tracks a one-bit
// reference model from the same D/e stimulus and compares Q/QNOT to it
// every cycle while a run is in CHECK.
module dff_response_monitor
  import dff_mon_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int SETTLE_CYC   = 1,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  input  logic             e,
  input  logic             Q,
  input  logic             QNOT,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] first_fail_idx
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC);
  localparam logic                HALT_ON_ERR = (STOP_ON_FAIL != 0);

  mon_state_e          state;
  mon_state_e          state_nxt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                exp_q;
  logic                run_clr;
  logic                in_check;
  logic                q_err;
  logic                c_err;
  logic                mismatch;

  // A new run may only begin from IDLE or DONE; start while busy is ignored.
  assign run_clr  = start && ((state == IDLE) || (state == DONE));
  assign in_check = (state == CHECK);
  // Q was set at the previous edge, as was exp_q, so they line up with no skew.
  assign q_err    = (Q != exp_q);
  assign c_err    = (QNOT != ~Q);
  assign mismatch = in_check && (q_err || c_err);

  // Reference flop: mirrors the DFF under test on every edge, whatever the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= 1'b0;
    end else if (e) begin
      exp_q <= D;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start beats stop in IDLE/DONE, and a mismatch in the
  // same CHECK cycle as stop is still counted before leaving.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = SETTLE;
      SETTLE: begin
        if (stop) begin
          state_nxt = DONE;
        end else if (settle_cnt <= SETTLE_W'(1)) begin
          state_nxt = CHECK;
        end
      end
      CHECK:  if (stop || (mismatch && HALT_ON_ERR)) state_nxt = DONE;
      DONE:   if (start) state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Settle delay: loaded at run start, counts down while in SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (run_clr) begin
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SETTLE_W'(1);
    end
  end

  // Sticky fail flag and index of the first failing compare in this run.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail           <= 1'b0;
      first_fail_idx <= '0;
    end else if (run_clr) begin
      fail           <= 1'b0;
      first_fail_idx <= '0;
    end else if (mismatch && !fail) begin
      fail           <= 1'b1;
      first_fail_idx <= sample_cnt;
    end
  end

  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (in_check),
    .cnt (sample_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (mismatch),
    .cnt (mismatch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .inc (in_check && e),
    .cnt (load_cnt)
  );

  // Status decoded straight from registered state and counters.
  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (mismatch_cnt == '0) && (sample_cnt != '0);

endmodule

// File: tb/tb_dff_response_monitor.sv
// Self-checking bench for dff_response_monitor: four monitor instances with
// different parameters, a behavioural DFF (good and enable-ignoring), and a
// scoreboard of expected end-of-run results.
module tb_dff_response_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d   = 1'b0;
  logic       e   = 1'b0;
  logic [3:0] start = '0;
  logic [3:0] stop  = '0;
  logic       fault_a = 1'b0;
  logic       force_b = 1'b0;
  logic       q_good = 1'b0;
  logic       q_noen = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Reference DFFs driven by the shared stimulus.
  always @(posedge clk) begin
    q_good <= rst ? 1'b0 : (e ? d : q_good);
    q_noen <= rst ? 1'b0 : d;
  end

  logic qa, qb, qnot_b;
  assign qa     = fault_a ? q_noen : q_good;
  assign qb     = q_good;
  assign qnot_b = force_b ? qb : ~qb;

  logic        a_busy, a_done, a_pass, a_fail;
  logic [15:0] a_sample, a_mism, a_load, a_ffi;
  logic        b_busy, b_done, b_pass, b_fail;
  logic [15:0] b_sample, b_mism, b_load, b_ffi;
  logic        c_busy, c_done, c_pass, c_fail;
  logic [3:0]  c_sample, c_mism, c_load, c_ffi;
  logic        d_busy, d_done, d_pass, d_fail;
  logic [15:0] d_sample, d_mism, d_load, d_ffi;

  dff_response_monitor #(.CNT_W(16), .SETTLE_CYC(1), .STOP_ON_FAIL(1)) u_a (
    .clk(clk), .rst(rst), .D(d), .e(e), .Q(qa), .QNOT(~qa),
    .start(start[0]), .stop(stop[0]),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail),
    .sample_cnt(a_sample), .mismatch_cnt(a_mism), .load_cnt(a_load),
    .first_fail_idx(a_ffi)
  );

  dff_response_monitor #(.CNT_W(16), .SETTLE_CYC(1), .STOP_ON_FAIL(0)) u_b (
    .clk(clk), .rst(rst), .D(d), .e(e), .Q(qb), .QNOT(qnot_b),
    .start(start[1]), .stop(stop[1]),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail),
    .sample_cnt(b_sample), .mismatch_cnt(b_mism), .load_cnt(b_load),
    .first_fail_idx(b_ffi)
  );

  dff_response_monitor #(.CNT_W(4), .SETTLE_CYC(1), .STOP_ON_FAIL(1)) u_c (
    .clk(clk), .rst(rst), .D(d), .e(e), .Q(q_good), .QNOT(~q_good),
    .start(start[2]), .stop(stop[2]),
    .busy(c_busy), .done(c_done), .pass(c_pass), .fail(c_fail),
    .sample_cnt(c_sample), .mismatch_cnt(c_mism), .load_cnt(c_load),
    .first_fail_idx(c_ffi)
  );

  dff_response_monitor #(.CNT_W(16), .SETTLE_CYC(3), .STOP_ON_FAIL(1)) u_d (
    .clk(clk), .rst(rst), .D(d), .e(e), .Q(q_good), .QNOT(~q_good),
    .start(start[3]), .stop(stop[3]),
    .busy(d_busy), .done(d_done), .pass(d_pass), .fail(d_fail),
    .sample_cnt(d_sample), .mismatch_cnt(d_mism), .load_cnt(d_load),
    .first_fail_idx(d_ffi)
  );

  // Per-instance views so checks can index by instance number.
  logic        o_busy [4];
  logic        o_done [4];
  logic        o_pass [4];
  logic        o_fail [4];
  logic [15:0] o_sample [4];
  logic [15:0] o_mism [4];
  logic [15:0] o_load [4];
  logic [15:0] o_ffi [4];

  always_comb begin
    o_busy   = '{a_busy, b_busy, c_busy, d_busy};
    o_done   = '{a_done, b_done, c_done, d_done};
    o_pass   = '{a_pass, b_pass, c_pass, d_pass};
    o_fail   = '{a_fail, b_fail, c_fail, d_fail};
    o_sample = '{a_sample, b_sample, {12'd0, c_sample}, d_sample};
    o_mism   = '{a_mism, b_mism, {12'd0, c_mism}, d_mism};
    o_load   = '{a_load, b_load, {12'd0, c_load}, d_load};
    o_ffi    = '{a_ffi, b_ffi, {12'd0, c_ffi}, d_ffi};
  end

  typedef struct {
    string       tag;
    int          inst;
    logic [15:0] sample;
    logic [15:0] mism;
    logic [15:0] load;
    logic [15:0] ffi;
    logic        done;
    logic        pass;
    logic        fail;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic expect_run(input string tag, input int inst, input int sample,
                            input int mism, input int load, input int ffi,
                            input logic dn, input logic ps, input logic fl);
    exp_t x;
    x.tag = tag; x.inst = inst;
    x.sample = 16'(sample); x.mism = 16'(mism); x.load = 16'(load); x.ffi = 16'(ffi);
    x.done = dn; x.pass = ps; x.fail = fl;
    sb.push_back(x);
  endtask

  // Pop the oldest expectation once its instance reports done (bounded wait).
  task automatic retire();
    exp_t x;
    int   n;
    x = sb.pop_front();
    n = 0;
    while (!o_done[x.inst] && (n < 50)) begin
      tick();
      n++;
    end
    check({x.tag, "_done"},     32'(o_done[x.inst]),   32'(x.done));
    check({x.tag, "_pass"},     32'(o_pass[x.inst]),   32'(x.pass));
    check({x.tag, "_fail"},     32'(o_fail[x.inst]),   32'(x.fail));
    check({x.tag, "_sample"},   32'(o_sample[x.inst]), 32'(x.sample));
    check({x.tag, "_mismatch"}, 32'(o_mism[x.inst]),   32'(x.mism));
    check({x.tag, "_load"},     32'(o_load[x.inst]),   32'(x.load));
    check({x.tag, "_ffi"},      32'(o_ffi[x.inst]),    32'(x.ffi));
  endtask

  initial begin
    #1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_busy%0d", i),   32'(o_busy[i]),   32'd0);
      check($sformatf("rst_done%0d", i),   32'(o_done[i]),   32'd0);
      check($sformatf("rst_pass%0d", i),   32'(o_pass[i]),   32'd0);
      check($sformatf("rst_fail%0d", i),   32'(o_fail[i]),   32'd0);
      check($sformatf("rst_cnts%0d", i),
            32'(o_sample[i] | o_mism[i] | o_load[i] | o_ffi[i]), 32'd0);
    end

    // Good DFF: 10 idle, 15 loads, 5 idle compares, stop on the 30th.
    do_reset();
    expect_run("s1", 0, 30, 0, 15, 0, 1'b1, 1'b1, 1'b0);
    pulse_start(0);
    check("s1_busy_settle", 32'(o_busy[0]), 32'd1);
    d = 1'b0; e = 1'b0;
    tick();
    for (int i = 0; i < 30; i++) begin
      d = (i >= 10) && (i < 25);
      e = (i >= 10) && (i < 25);
      stop[0] = (i == 29);
      tick();
    end
    stop[0] = 1'b0; d = 1'b0; e = 1'b0;
    retire();

    // Enable-ignoring DFF: D rises with e=0, first divergence at compare 3.
    fault_a = 1'b1;
    do_reset();
    expect_run("s2", 0, 4, 1, 0, 3, 1'b1, 1'b0, 1'b1);
    pulse_start(0);
    tick();
    for (int i = 0; i < 8; i++) begin
      d = (i >= 2); e = 1'b0;
      tick();
    end
    d = 1'b0;
    retire();
    fault_a = 1'b0;

    // QNOT stuck equal to Q from compare 5 on, keep checking, 10 compares.
    do_reset();
    expect_run("s3", 1, 10, 5, 5, 5, 1'b1, 1'b0, 1'b1);
    pulse_start(1);
    tick();
    for (int i = 0; i < 10; i++) begin
      d = i[1]; e = i[0];
      force_b = (i >= 5);
      stop[1] = (i == 9);
      tick();
    end
    force_b = 1'b0; stop[1] = 1'b0; d = 1'b0; e = 1'b0;
    retire();

    // 4-bit counters: 20 good compares saturate sample_cnt at 15.
    do_reset();
    expect_run("s4", 2, 15, 0, 10, 0, 1'b1, 1'b1, 1'b0);
    pulse_start(2);
    tick();
    for (int i = 0; i < 20; i++) begin
      d = i[1]; e = i[0];
      stop[2] = (i == 19);
      tick();
    end
    stop[2] = 1'b0; d = 1'b0; e = 1'b0;
    retire();

    // Reset mid-CHECK abandons the run; then start+stop in IDLE and start while busy.
    do_reset();
    pulse_start(0);
    tick();
    for (int i = 0; i < 7; i++) begin
      d = i[0]; e = 1'b1;
      tick();
    end
    check("s5_pre_rst_sample", 32'(o_sample[0]), 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_rst_busy",   32'(o_busy[0]),   32'd0);
    check("s5_rst_done",   32'(o_done[0]),   32'd0);
    check("s5_rst_sample", 32'(o_sample[0]), 32'd0);
    check("s5_rst_load",   32'(o_load[0]),   32'd0);
    expect_run("s5", 0, 6, 0, 6, 0, 1'b1, 1'b1, 1'b0);
    start[0] = 1'b1; stop[0] = 1'b1;
    tick();
    start[0] = 1'b0; stop[0] = 1'b0;
    check("s5_startstop_busy", 32'(o_busy[0]), 32'd1);
    check("s5_startstop_done", 32'(o_done[0]), 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      d = i[0]; e = 1'b1;
      start[0] = (i == 3);
      stop[0]  = (i == 5);
      tick();
    end
    start[0] = 1'b0; stop[0] = 1'b0; d = 1'b0; e = 1'b0;
    retire();

    // SETTLE_CYC=3: stop during settle ends with no compares.
    do_reset();
    expect_run("s6", 3, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    pulse_start(3);
    tick();
    check("s6_busy", 32'(o_busy[3]), 32'd1);
    stop[3] = 1'b1;
    tick();
    stop[3] = 1'b0;
    retire();

    // Restart from DONE: first compare lands SETTLE_CYC+1 edges after start.
    pulse_start(3);
    d = 1'b1; e = 1'b1;
    tick();
    tick();
    check("s6b_settle_sample", 32'(o_sample[3]), 32'd0);
    check("s6b_settle_busy",   32'(o_busy[3]),   32'd1);
    tick();
    check("s6b_enter_check_sample", 32'(o_sample[3]), 32'd0);
    tick();
    check("s6b_first_compare", 32'(o_sample[3]), 32'd1);
    expect_run("s6b", 3, 2, 0, 2, 0, 1'b1, 1'b1, 1'b0);
    stop[3] = 1'b1;
    tick();
    stop[3] = 1'b0; d = 1'b0; e = 1'b0;
    retire();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
